// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VDP pixel fetches first, then buffered CPU writes, then one CPU read.
// RAM ports are registered; returned data is routed by a two-stage slot tag.
module vram_arbiter #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] vdp_addr,
   output logic [7:0]  vdp_data,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_we,
   input  logic        cpu_rd,
   output logic        cpu_ready,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_rvalid,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   input  logic [7:0]  mem_rdata
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      SLOT_IDLE,
      SLOT_VDP,
      SLOT_WR,
      SLOT_RD
   } slot_e;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_entry_t;

   wr_entry_t        fifo_mem [FIFO_DEPTH];
   wr_entry_t        head;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic [15:0]      fetch_addr;
   logic             fetch_valid;
   logic             rd_pending;
   logic [15:0]      rd_addr;
   slot_e            slot_sel, slot_q, rdata_slot;
   logic [7:0]       vdp_data_q, cpu_rdata_q;
   logic             push, pop, rd_accept;

   assign head      = fifo_mem[rd_ptr];
   assign cpu_ready = (count != FULL_CNT) && !rd_pending;
   // A simultaneous write+read request is treated as a write only.
   assign push      = cpu_we && cpu_ready;
   assign rd_accept = cpu_rd && !cpu_we && cpu_ready;
   assign pop       = (slot_sel == SLOT_WR);

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      slot_sel = SLOT_IDLE;
      if (!fetch_valid || (vdp_addr != fetch_addr)) slot_sel = SLOT_VDP;
      else if (count != '0)                         slot_sel = SLOT_WR;
      else if (rd_pending)                          slot_sel = SLOT_RD;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_we     <= 1'b0;
         slot_q     <= SLOT_IDLE;
         rdata_slot <= SLOT_IDLE;
      end else begin
         mem_we     <= pop;
         slot_q     <= slot_sel;
         rdata_slot <= slot_q;
         case (slot_sel)
            SLOT_VDP: mem_addr <= vdp_addr;
            SLOT_WR: begin
               mem_addr  <= head.addr;
               mem_wdata <= head.data;
            end
            SLOT_RD:  mem_addr <= rd_addr;
            default:  ;
         endcase
      end
   end

   // A write landing on the displayed address invalidates the fetched byte.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_addr  <= '0;
         fetch_valid <= 1'b0;
      end else if (slot_sel == SLOT_VDP) begin
         fetch_addr  <= vdp_addr;
         fetch_valid <= 1'b1;
      end else if (pop && (head.addr == fetch_addr)) begin
         fetch_valid <= 1'b0;
      end
   end

   // NOTE: FIFO storage has no reset; the count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= '{addr: cpu_addr, data: cpu_wdata};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_pending <= 1'b0;
         rd_addr    <= '0;
      end else if (rd_accept) begin
         rd_pending <= 1'b1;
         rd_addr    <= cpu_addr;
      end else if (slot_sel == SLOT_RD) begin
         rd_pending <= 1'b0;
      end
   end

   // Returned bytes are shown as soon as the RAM delivers them, then held.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vdp_data_q  <= '0;
         cpu_rdata_q <= '0;
      end else begin
         if (rdata_slot == SLOT_VDP) vdp_data_q  <= mem_rdata;
         if (rdata_slot == SLOT_RD)  cpu_rdata_q <= mem_rdata;
      end
   end

   assign vdp_data   = (rdata_slot == SLOT_VDP) ? mem_rdata : vdp_data_q;
   assign cpu_rvalid = (rdata_slot == SLOT_RD);
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM (one-cycle read latency).
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] vdp_addr;
   logic [7:0]  vdp_data;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_we;
   logic        cpu_rd;
   logic        cpu_ready;
   logic [7:0]  cpu_rdata;
   logic        cpu_rvalid;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata = '0;

   logic [7:0]  ram [65536];
   int          n_cmp = 0;
   int          n_err = 0;

   vram_arbiter #(.FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .vdp_addr   (vdp_addr),
      .vdp_data   (vdp_data),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_we     (cpu_we),
      .cpu_rd     (cpu_rd),
      .cpu_ready  (cpu_ready),
      .cpu_rdata  (cpu_rdata),
      .cpu_rvalid (cpu_rvalid),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] wr_addr [8];
      logic [7:0]  wr_data [8];
      int          n_wr;
      int          n_rv;
      logic [15:0] seen_addr;

      for (int a = 0; a < 65536; a++) ram[a] = '0;
      ram[16'h0123] = 8'hA5;
      ram[16'h0040] = 8'h11;
      for (int a = 0; a < 4; a++) ram[16'h0200 + a] = 8'hC0 + 8'(a);

      reset     = 1'b0;
      vdp_addr  = '0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      cpu_we    = 1'b0;
      cpu_rd    = 1'b0;
      #12 reset = 1'b1;
      step();

      // Reset state
      check("rst_ready",  32'(cpu_ready),  32'd1);
      check("rst_mem_we", 32'(mem_we),     32'd0);
      check("rst_rvalid", 32'(cpu_rvalid), 32'd0);
      check("rst_vdp",    32'(vdp_data),   32'h00);
      step();
      step();

      // VDP fetch latency
      vdp_addr = 16'h0123;
      step();
      check("vdp_n1_addr", 32'(mem_addr), 32'h0123);
      check("vdp_n1_data", 32'(vdp_data), 32'h00);
      step();
      check("vdp_n2_data", 32'(vdp_data), 32'hA5);
      step();
      check("vdp_hold",    32'(vdp_data), 32'hA5);
      check("vdp_no_we",   32'(mem_we),   32'd0);

      // Read after write
      cpu_we = 1'b1; cpu_addr = 16'h2000; cpu_wdata = 8'h3C;
      step();
      cpu_we = 1'b0; cpu_rd = 1'b1;
      check("raw_ready_q1", 32'(cpu_ready), 32'd1);
      step();
      cpu_rd = 1'b0;
      check("raw_wr_we",    32'(mem_we),    32'd1);
      check("raw_wr_addr",  32'(mem_addr),  32'h2000);
      check("raw_wr_data",  32'(mem_wdata), 32'h3C);
      check("raw_pend_rdy", 32'(cpu_ready), 32'd0);
      step();
      check("raw_rd_we",    32'(mem_we),    32'd0);
      check("raw_rd_addr",  32'(mem_addr),  32'h2000);
      check("raw_rv_early", 32'(cpu_rvalid), 32'd0);
      step();
      check("raw_rvalid",   32'(cpu_rvalid), 32'd1);
      check("raw_rdata",    32'(cpu_rdata),  32'h3C);
      step();
      check("raw_rv_pulse", 32'(cpu_rvalid), 32'd0);
      check("raw_ready",    32'(cpu_ready),  32'd1);

      // Coherence on the displayed address
      vdp_addr = 16'h0040;
      step(); step(); step();
      check("coh_before", 32'(vdp_data), 32'h11);
      cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 8'h77;
      step();
      cpu_we = 1'b0;
      step();
      check("coh_wr_we", 32'(mem_we), 32'd1);
      for (int k = 0; k < 3; k++) begin
         step();
         if (vdp_data == 8'h77) break;
      end
      check("coh_after", 32'(vdp_data), 32'h77);
      step(); step();

      // FIFO full while the VDP hogs every slot
      for (int i = 0; i < 5; i++) begin
         vdp_addr  = 16'h0100 + 16'(i);
         cpu_we    = 1'b1;
         cpu_addr  = 16'h3000 + 16'(i);
         cpu_wdata = 8'h50 + 8'(i);
         check($sformatf("full_ready_%0d", i), 32'(cpu_ready), 32'(i < 4));
         step();
      end
      cpu_we = 1'b0;
      check("full_ready_after", 32'(cpu_ready), 32'd0);
      n_wr = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (mem_we && n_wr < 8) begin
            wr_addr[n_wr] = mem_addr;
            wr_data[n_wr] = mem_wdata;
            n_wr++;
         end
      end
      check("full_n_writes", 32'(n_wr), 32'd4);
      for (int j = 0; j < 4; j++) begin
         check($sformatf("full_addr_%0d", j), 32'(wr_addr[j]), 32'h3000 + 32'(j));
         check($sformatf("full_data_%0d", j), 32'(wr_data[j]), 32'h50 + 32'(j));
      end

      // Simultaneous write and read request
      cpu_we = 1'b1; cpu_rd = 1'b1; cpu_addr = 16'h4000; cpu_wdata = 8'h99;
      step();
      cpu_we = 1'b0; cpu_rd = 1'b0;
      check("both_ready", 32'(cpu_ready), 32'd1);
      n_wr = 0; n_rv = 0; seen_addr = '0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (mem_we) begin
            n_wr++;
            seen_addr = mem_addr;
         end
         if (cpu_rvalid) n_rv++;
      end
      check("both_n_writes", 32'(n_wr),      32'd1);
      check("both_wr_addr",  32'(seen_addr), 32'h4000);
      check("both_n_rvalid", 32'(n_rv),      32'd0);

      // Reset in the middle of a drain
      for (int i = 0; i < 3; i++) begin
         vdp_addr  = 16'h0200 + 16'(i);
         cpu_we    = 1'b1;
         cpu_addr  = 16'h5000 + 16'(i);
         cpu_wdata = 8'hE0 + 8'(i);
         step();
      end
      cpu_we   = 1'b0;
      vdp_addr = 16'h0203;
      step();
      step();
      check("mid_drain_we",  32'(mem_we),   32'd1);
      check("mid_drain_vdp", 32'(vdp_data), 32'hC3);
      #2 reset = 1'b0;
      #1;
      check("arst_vdp_data",  32'(vdp_data),   32'h00);
      check("arst_cpu_rdata", 32'(cpu_rdata),  32'h00);
      check("arst_rvalid",    32'(cpu_rvalid), 32'd0);
      check("arst_mem_addr",  32'(mem_addr),   32'h0000);
      check("arst_mem_wdata", 32'(mem_wdata),  32'h00);
      check("arst_mem_we",    32'(mem_we),     32'd0);
      #10 reset = 1'b1;
      #1;
      check("arst_ready", 32'(cpu_ready), 32'd1);
      n_wr = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (mem_we) n_wr++;
      end
      check("arst_no_writes", 32'(n_wr), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
